// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter: dynamic two-master Wishbone arbiter (M0 = CPU, M1 = wb_ext).
// Round-robin on contention, a grant is never revoked while its owner holds cyc,
// and ownership is handed straight to a waiting master with no idle cycle.
// Optional slave-timeout logic is enabled with `define WB_ARB_TIMEOUT_EN.
module wb_master_arbiter #(
   parameter int unsigned                WB_DATA_WIDTH  = 32,
   parameter int unsigned                WB_ADDR_WIDTH  = 32,
   parameter int unsigned                WB_SEL_WIDTH   = 4,
   parameter int unsigned                TIMEOUT_CYCLES = 256,
   parameter logic [WB_DATA_WIDTH-1:0]   ERR_DATA       = 32'hDEAD_BEEF
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   // master 0 (CPU)
   input  logic [WB_ADDR_WIDTH-1:0] m0_addr_i,
   input  logic [WB_DATA_WIDTH-1:0] m0_data_i,
   input  logic                     m0_we_i,
   input  logic [WB_SEL_WIDTH-1:0]  m0_sel_i,
   input  logic                     m0_stb_i,
   input  logic                     m0_cyc_i,
   output logic                     m0_ack_o,
   output logic [WB_DATA_WIDTH-1:0] m0_data_o,
   // master 1 (external port)
   input  logic [WB_ADDR_WIDTH-1:0] m1_addr_i,
   input  logic [WB_DATA_WIDTH-1:0] m1_data_i,
   input  logic                     m1_we_i,
   input  logic [WB_SEL_WIDTH-1:0]  m1_sel_i,
   input  logic                     m1_stb_i,
   input  logic                     m1_cyc_i,
   output logic                     m1_ack_o,
   output logic [WB_DATA_WIDTH-1:0] m1_data_o,
   // slave side
   output logic [WB_ADDR_WIDTH-1:0] s_addr_o,
   output logic [WB_DATA_WIDTH-1:0] s_data_o,
   output logic                     s_we_o,
   output logic [WB_SEL_WIDTH-1:0]  s_sel_o,
   output logic                     s_stb_o,
   output logic                     s_cyc_o,
   input  logic                     s_ack_i,
   input  logic [WB_DATA_WIDTH-1:0] s_data_i,
   // status
   output logic [1:0]               grant_o,
   output logic                     timeout_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_M0 = 2'd1,
      GNT_M1 = 2'd2
   } state_e;

   state_e     state_q;
   logic [1:0] grant_q;
   logic       last_m1_q;   // 1: M1 was the most recent owner

   logic       own0;
   logic       own1;
   logic       own_cyc;
   logic       own_stb;
   logic       tmo;

   // Arbitration FSM with registered one-hot grant and round-robin history
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         last_m1_q <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (m0_cyc_i && (!m1_cyc_i || last_m1_q)) begin
                  state_q   <= GNT_M0;
                  grant_q   <= 2'b01;
                  last_m1_q <= 1'b0;
               end else if (m1_cyc_i) begin
                  state_q   <= GNT_M1;
                  grant_q   <= 2'b10;
                  last_m1_q <= 1'b1;
               end
            end
            GNT_M0: begin
               if (!m0_cyc_i) begin
                  if (m1_cyc_i) begin
                     state_q   <= GNT_M1;
                     grant_q   <= 2'b10;
                     last_m1_q <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                     grant_q <= '0;
                  end
               end
            end
            GNT_M1: begin
               if (!m1_cyc_i) begin
                  if (m0_cyc_i) begin
                     state_q   <= GNT_M0;
                     grant_q   <= 2'b01;
                     last_m1_q <= 1'b0;
                  end else begin
                     state_q <= IDLE;
                     grant_q <= '0;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= '0;
            end
         endcase
      end
   end

   assign own0    = grant_q[0];
   assign own1    = grant_q[1];
   assign grant_o = grant_q;

`ifdef WB_ARB_TIMEOUT_EN
   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CW-1:0] wait_cnt_q;
   logic [CW-1:0] wait_cnt_d;

   // Wait counter next state; the owner's cyc dropping is the only way a grant
   // changes, so clearing on !own_cyc covers the grant-change case
   always_comb begin
      wait_cnt_d = wait_cnt_q + 1'b1;
      if (!own_cyc || !own_stb || s_ack_i || tmo) begin
         wait_cnt_d = '0;
      end
   end

   // Wait counter register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign tmo = own_stb && !s_ack_i && (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
   assign tmo = 1'b0;
`endif

   assign timeout_o = tmo;

   // Forward the owner's cycle to the slave; all zero while idle
   always_comb begin
      own_cyc  = 1'b0;
      own_stb  = 1'b0;
      s_addr_o = '0;
      s_data_o = '0;
      s_we_o   = 1'b0;
      s_sel_o  = '0;
      if (own0) begin
         own_cyc  = m0_cyc_i;
         own_stb  = m0_stb_i & m0_cyc_i;
         s_addr_o = m0_addr_i;
         s_data_o = m0_data_i;
         s_we_o   = m0_we_i;
         s_sel_o  = m0_sel_i;
      end else if (own1) begin
         own_cyc  = m1_cyc_i;
         own_stb  = m1_stb_i & m1_cyc_i;
         s_addr_o = m1_addr_i;
         s_data_o = m1_data_i;
         s_we_o   = m1_we_i;
         s_sel_o  = m1_sel_i;
      end
      s_cyc_o = own_cyc;
      s_stb_o = own_stb & ~tmo;
   end

   // Return path: only a strobing owner sees ack/data, timeouts substitute ERR_DATA
   always_comb begin
      m0_ack_o  = 1'b0;
      m0_data_o = '0;
      m1_ack_o  = 1'b0;
      m1_data_o = '0;
      if (own0) begin
         m0_ack_o  = own_stb & (s_ack_i | tmo);
         m0_data_o = tmo ? ERR_DATA : s_data_i;
      end else if (own1) begin
         m1_ack_o  = own_stb & (s_ack_i | tmo);
         m1_data_o = tmo ? ERR_DATA : s_data_i;
      end
   end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: reset, single master, tie, round-robin,
// isolation, stray ack while idle, and slave timeout (or stall without the macro).
module tb_wb_master_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] m0_addr, m0_wdat, m1_addr, m1_wdat;
   logic        m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc;
   logic [3:0]  m0_sel, m1_sel;
   logic        m0_ack, m1_ack;
   logic [31:0] m0_rdat, m1_rdat;
   logic [31:0] s_addr, s_wdat, s_rdat;
   logic        s_we, s_stb, s_cyc, s_ack;
   logic [3:0]  s_sel;
   logic [1:0]  grant;
   logic        timeout;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   wb_master_arbiter #(
      .WB_DATA_WIDTH (32),
      .WB_ADDR_WIDTH (32),
      .WB_SEL_WIDTH  (4),
      .TIMEOUT_CYCLES(16),
      .ERR_DATA      (32'hDEAD_BEEF)
   ) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .m0_addr_i(m0_addr), .m0_data_i(m0_wdat), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
      .m0_stb_i (m0_stb),  .m0_cyc_i (m0_cyc),  .m0_ack_o(m0_ack), .m0_data_o(m0_rdat),
      .m1_addr_i(m1_addr), .m1_data_i(m1_wdat), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
      .m1_stb_i (m1_stb),  .m1_cyc_i (m1_cyc),  .m1_ack_o(m1_ack), .m1_data_o(m1_rdat),
      .s_addr_o (s_addr),  .s_data_o (s_wdat),  .s_we_o  (s_we),   .s_sel_o  (s_sel),
      .s_stb_o  (s_stb),   .s_cyc_o  (s_cyc),   .s_ack_i (s_ack),  .s_data_i (s_rdat),
      .grant_o  (grant),
      .timeout_o(timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int acks;
      int tmos;
      int stb_low;

      rst_n  = 1'b0;
      m0_addr = '0; m0_wdat = '0; m0_we = 1'b0; m0_sel = '0; m0_stb = 1'b0; m0_cyc = 1'b0;
      m1_addr = '0; m1_wdat = '0; m1_we = 1'b0; m1_sel = '0; m1_stb = 1'b0; m1_cyc = 1'b0;
      s_ack = 1'b0; s_rdat = '0;
      #12;
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_s_cyc", 32'(s_cyc), 32'h0);
      chk("rst_timeout", 32'(timeout), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();

      // single master read from M0
      m0_addr = 32'h1000; m0_sel = 4'hF; m0_cyc = 1'b1; m0_stb = 1'b1;
      #1;
      chk("t2_idle_grant", 32'(grant), 32'h0);
      chk("t2_idle_s_stb", 32'(s_stb), 32'h0);
      tick();
      chk("t2_grant", 32'(grant), 32'h1);
      chk("t2_s_stb", 32'(s_stb), 32'h1);
      chk("t2_s_addr", s_addr, 32'h1000);
      chk("t2_no_ack_yet", 32'(m0_ack), 32'h0);
      tick();
      s_ack = 1'b1; s_rdat = 32'h1234_5678;
      #1;
      chk("t2_ack", 32'(m0_ack), 32'h1);
      chk("t2_rdata", m0_rdat, 32'h1234_5678);
      chk("t2_m1_ack", 32'(m1_ack), 32'h0);
      chk("t2_m1_data", m1_rdat, 32'h0);
      tick();
      s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
      #1;
      chk("t2_s_cyc_gated", 32'(s_cyc), 32'h0);
      chk("t2_grant_held", 32'(grant), 32'h1);
      tick();
      chk("t2_idle_after", 32'(grant), 32'h0);

      // asynchronous reset mid-transfer
      m0_cyc = 1'b1; m0_stb = 1'b1;
      tick();
      s_ack = 1'b1;
      #1;
      chk("t1_pre_ack", 32'(m0_ack), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("t1_grant", 32'(grant), 32'h0);
      chk("t1_s_cyc", 32'(s_cyc), 32'h0);
      chk("t1_m0_ack", 32'(m0_ack), 32'h0);
      s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      // tie from reset: M0 first, then zero-gap handoff to M1
      m0_addr = 32'h0000_0100; m0_cyc = 1'b1; m0_stb = 1'b1;
      m1_addr = 32'h2000;      m1_cyc = 1'b1; m1_stb = 1'b1;
      tick();
      chk("t3_tie_m0", 32'(grant), 32'h1);
      m0_cyc = 1'b0; m0_stb = 1'b0;
      #1;
      chk("t3_hold", 32'(grant), 32'h1);
      tick();
      chk("t3_handoff_m1", 32'(grant), 32'h2);

      // isolation while M1 owns, M1 write reaches the slave
      m1_we = 1'b1; m1_wdat = 32'hA5A5_A5A5; m1_sel = 4'hF;
      m0_addr = 32'h0000_0300; m0_cyc = 1'b1; m0_stb = 1'b1;
      s_ack = 1'b1; s_rdat = 32'h0BAD_F00D;
      #1;
      chk("t5_m0_ack_iso", 32'(m0_ack), 32'h0);
      chk("t5_m0_data_iso", m0_rdat, 32'h0);
      chk("t5_m1_ack", 32'(m1_ack), 32'h1);
      chk("t5_s_addr", s_addr, 32'h2000);
      chk("t4_s_data", s_wdat, 32'hA5A5_A5A5);
      chk("t4_s_sel", 32'(s_sel), 32'hF);
      chk("t4_s_we", 32'(s_we), 32'h1);
      s_ack = 1'b0;
      #1;
      chk("t5_m0_ack_iso2", 32'(m0_ack), 32'h0);
      chk("t5_m1_ack_low", 32'(m1_ack), 32'h0);

      // round-robin: each master finishes one transfer, the other is waiting
      m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
      tick();
      chk("t4_rr_m0", 32'(grant), 32'h1);
      chk("t4_rr_m0_addr", s_addr, 32'h0000_0300);
      m1_cyc = 1'b1; m1_stb = 1'b1;
      s_ack = 1'b1;
      #1;
      chk("t4_rr_m0_ack", 32'(m0_ack), 32'h1);
      tick();
      s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
      tick();
      chk("t4_rr_m1", 32'(grant), 32'h2);
      m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b0; m1_stb = 1'b0;
      tick();
      chk("t4_rr_m0_again", 32'(grant), 32'h1);
      m0_cyc = 1'b0; m0_stb = 1'b0;
      tick();
      chk("t4_idle", 32'(grant), 32'h0);

      // stray ack while idle is ignored
      s_ack = 1'b1;
      #1;
      chk("idle_ack_m0", 32'(m0_ack), 32'h0);
      chk("idle_ack_m1", 32'(m1_ack), 32'h0);
      chk("idle_s_stb", 32'(s_stb), 32'h0);
      s_ack = 1'b0;
      tick();

      // hung slave on an M0 read
      m0_addr = 32'h4000; m0_we = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1; s_rdat = 32'h5555_AAAA;
      tick();
      acks = 0; tmos = 0; stb_low = 0;
`ifdef WB_ARB_TIMEOUT_EN
      for (int i = 1; i < 16; i++) begin
         #1;
         if (m0_ack) acks++;
         if (timeout) tmos++;
         if (!s_stb) stb_low++;
         tick();
      end
      chk("t6_early_acks", 32'(acks), 32'h0);
      chk("t6_early_tmo", 32'(tmos), 32'h0);
      chk("t6_early_stb_low", 32'(stb_low), 32'h0);
      #1;
      chk("t6_ack", 32'(m0_ack), 32'h1);
      chk("t6_err_data", m0_rdat, 32'hDEAD_BEEF);
      chk("t6_timeout", 32'(timeout), 32'h1);
      chk("t6_s_stb_masked", 32'(s_stb), 32'h0);
      tick();
      chk("t6_tmo_once", 32'(timeout), 32'h0);
      chk("t6_ack_after", 32'(m0_ack), 32'h0);
      chk("t6_stb_back", 32'(s_stb), 32'h1);
`else
      for (int i = 0; i < 1000; i++) begin
         if (m0_ack) acks++;
         if (timeout) tmos++;
         tick();
      end
      chk("t6_no_ack", 32'(acks), 32'h0);
      chk("t6_no_timeout", 32'(tmos), 32'h0);
      chk("t6_still_granted", 32'(grant), 32'h1);
`endif
      m0_cyc = 1'b0; m0_stb = 1'b0;
      tick();
      chk("end_idle", 32'(grant), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
